reg_scoreboard: RTL

Pending-write scoreboard for the 15-entry general register file in the pipelined core. Sits in the decode stage. It tracks how many issued instructions still owe a write-back to each register, stalls decode on read-after-write hazards, and stalls on write-count overflow. Entries are released by the register-file write-back port.

---
 rtl/reg_scoreboard.sv | 81 ++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the general register file: per-register write-back
// counters, RAW/overflow decode stall, sticky flag for spurious write-backs.
module reg_scoreboard #(
    parameter int unsigned NREGS = 15,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [3:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             hold,
    input  logic             writeBackEn,
    input  logic [3:0]       Dest_wb,
    output logic             stall,
    output logic             issue,
    output logic [NREGS-1:0] pending,
    output logic             wb_err
);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [CNT_W-1:0] eff [NREGS];
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] inc;
    logic             raw_hazard;
    logic             ovf_hazard;
    logic             spurious_wb;

    // Index 15 never matches any loop index, so it is ignored on every port.
    always_comb begin
        raw_hazard  = 1'b0;
        ovf_hazard  = 1'b0;
        spurious_wb = 1'b0;
        dec         = '0;
        pending     = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            dec[i]     = writeBackEn && (Dest_wb == 4'(i)) && (cnt[i] != '0);
            eff[i]     = cnt[i] - CNT_W'(dec[i]);
            pending[i] = (cnt[i] != '0);
            if (id_use_src1 && (id_src1 == 4'(i)) && (eff[i] != '0))
                raw_hazard = 1'b1;
            if (id_use_src2 && (id_src2 == 4'(i)) && (eff[i] != '0))
                raw_hazard = 1'b1;
            if (id_wb_en && (id_dest == 4'(i)) && (eff[i] == '1))
                ovf_hazard = 1'b1;
            if (writeBackEn && (Dest_wb == 4'(i)) && (cnt[i] == '0))
                spurious_wb = 1'b1;
        end
    end

    assign stall = id_valid && (raw_hazard || ovf_hazard);
    assign issue = id_valid && !stall && !hold;

    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            inc[i] = issue && id_wb_en && (id_dest == 4'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                cnt[i] <= '0;
            wb_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (inc[i] && !dec[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec[i] && !inc[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
            if (spurious_wb)
                wb_err <= 1'b1;
        end
    end

endmodule
